// File: rtl/exc_arbiter.sv
// exc_arbiter: commit-boundary arbiter for eret, interrupts and syscall, with edge-latched interrupt pending bits.
// Define TIMER_INTR_EN to let intimer feed pend[0]; otherwise the timer source is ignored.
module exc_arbiter #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  intr,
  input  logic        intimer,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  input  logic        instValid,
  input  logic        isSyscall,
  input  logic        isEret,
  input  logic [31:0] pc,
  output logic [31:0] excptype,
  output logic [31:0] excpc,
  output logic        flush,
  output logic [31:0] newPc,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, TAKE, SETTLE} state_e;
  state_e      state_q, state_d;
  logic [5:0]  intr_q;
  logic        tim_q;
  logic [6:0]  pend_q, pend_d, rise, masked, lowest;
  logic [1:0]  ev_q, ev_d;
  logic [31:0] excpc_q, excpc_d, newpc_q, newpc_d;
  logic        int_req, sel;
`ifdef TIMER_INTR_EN
  logic        unused_status;
  assign rise = {intr & ~intr_q, intimer & ~tim_q};
  assign masked = pend_q & {status[15:10], status[8]};
  assign unused_status = ^{status[31:16], status[9], status[7:2]};
`else
  logic        unused_status;
  assign rise = {intr & ~intr_q, 1'b0};
  assign masked = pend_q & {status[15:10], 1'b0};
  assign unused_status = ^{status[31:16], status[9:2], intimer, tim_q};
`endif
  // Isolate the lowest-index masked pending source for servicing
  assign lowest = masked & (~masked + 7'd1);
  assign int_req = status[0] & ~status[1] & (|masked);
  assign sel = (state_q == IDLE) & instValid & (isEret | int_req | isSyscall);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      intr_q  <= '0;
      tim_q   <= 1'b0;
      pend_q  <= '0;
      ev_q    <= '0;
      excpc_q <= '0;
      newpc_q <= '0;
    end else begin
      state_q <= state_d;
      intr_q  <= intr;
      tim_q   <= intimer;
      pend_q  <= pend_d;
      ev_q    <= ev_d;
      excpc_q <= excpc_d;
      newpc_q <= newpc_d;
    end
  end
  // Event codes in ev_q: 1 interrupt, 2 syscall, 3 eret
  always_comb begin
    state_d = state_q == IDLE ? (sel ? TAKE : IDLE) : state_q == TAKE ? SETTLE : IDLE;
    ev_d    = sel ? (isEret ? 2'd3 : int_req ? 2'd1 : 2'd2) : ev_q;
    excpc_d = sel ? pc : excpc_q;
    newpc_d = sel ? (isEret ? epc : HANDLER_ADDR) : newpc_q;
    pend_d  = (pend_q & ~((sel & ~isEret & int_req) ? lowest : 7'd0)) | rise;
  end
  always_comb begin
    flush    = state_q == TAKE;
    busy     = state_q != IDLE;
    excptype = !flush ? 32'h0 : ev_q == 2'd3 ? 32'h200 : ev_q == 2'd1 ? 32'h4 : 32'h100;
    excpc    = excpc_q;
    newPc    = newpc_q;
  end
endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: directed plus randomized scoreboard bench for exc_arbiter against an event-level reference model.
module tb_exc_arbiter;
  logic        clk = 1'b0;
  logic        rst, intimer, instValid, isSyscall, isEret, flush, busy;
  logic [5:0]  intr;
  logic [31:0] status, epc, pc, excptype, excpc, newPc;
  typedef struct {logic [31:0] t; logic [31:0] p; logic [31:0] n;} ev_t;
  ev_t         q[$];
  ev_t         mon_e;
  int          checks = 0, errors = 0, cool = 0;
  bit          done = 0, exp_busy = 0, m_pt = 0;
  bit [6:0]    m_pend = 0;
  bit [5:0]    m_pi = 0;
  logic [31:0] m_pc = 0, m_np = 0;

  exc_arbiter #(.HANDLER_ADDR(32'h0000_0080)) dut (
    .clk(clk), .rst(rst), .intr(intr), .intimer(intimer), .status(status), .epc(epc),
    .instValid(instValid), .isSyscall(isSyscall), .isEret(isEret), .pc(pc),
    .excptype(excptype), .excpc(excpc), .flush(flush), .newPc(newPc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  // Reference: an event is accepted only when no event is within its 2-cycle shadow
  task automatic model_eval();
    bit [6:0] r, msk;
    ev_t e;
    bit hit;
    if (rst) begin
      m_pend = 0; m_pi = 0; m_pt = 0; cool = 0; m_pc = 0; m_np = 0; exp_busy = 0;
      return;
    end
`ifdef TIMER_INTR_EN
    r = {intr & ~m_pi, intimer & ~m_pt};
    msk = m_pend & {status[15:10], status[8]};
`else
    r = {intr & ~m_pi, 1'b0};
    msk = m_pend & {status[15:10], 1'b0};
`endif
    hit = 0;
    if (cool > 0) cool--;
    else if (instValid) begin
      if (isEret) begin
        e = '{32'h200, pc, epc}; hit = 1;
      end else if (status[0] && !status[1] && msk != 0) begin
        e = '{32'h4, pc, 32'h80}; hit = 1;
        for (int i = 0; i < 7; i++) if (msk[i]) begin m_pend[i] = 0; break; end
      end else if (isSyscall) begin
        e = '{32'h100, pc, 32'h80}; hit = 1;
      end
    end
    if (hit) begin
      q.push_back(e); cool = 2; m_pc = e.p; m_np = e.n;
    end
    m_pend |= r; m_pi = intr; m_pt = intimer; exp_busy = cool > 0;
  endtask

  task automatic drv(bit r, bit iv, bit sc, bit er, logic [5:0] in, bit tm,
                     logic [31:0] st, logic [31:0] ep, logic [31:0] p);
    @(negedge clk);
    rst = r; instValid = iv; isSyscall = sc; isEret = er; intr = in; intimer = tm;
    status = st; epc = ep; pc = p;
    model_eval();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      chk("busy", busy, exp_busy);
      chk("excpc_held", excpc, m_pc);
      chk("newPc_held", newPc, m_np);
      if (flush) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_flush got excptype %h want no event", excptype);
        end else begin
          mon_e = q.pop_front();
          chk("excptype", excptype, mon_e.t);
          chk("ev_excpc", excpc, mon_e.p);
          chk("ev_newPc", newPc, mon_e.n);
        end
      end else begin
        chk("idle_excptype", excptype, 32'h0);
        if (q.size() != 0) begin
          checks++; errors++;
          $display("FAIL missed_event got flush 0 want excptype %h", q[0].t);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [5:0] ri;
    logic [31:0] st;
    rst = 1; instValid = 0; isSyscall = 0; isEret = 0; intr = 0; intimer = 0;
    status = 0; epc = 0; pc = 0;
    model_eval();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // interrupt on intr[0]
    drv(0, 0, 0, 0, 6'h00, 0, 32'h401, 0, 0);
    drv(0, 0, 0, 0, 6'h01, 0, 32'h401, 0, 0);
    drv(0, 1, 0, 0, 6'h01, 0, 32'h401, 0, 32'h100);
    repeat (3) drv(0, 1, 0, 0, 6'h01, 0, 32'h401, 0, 32'h104);
    // syscall with nothing pending
    drv(0, 1, 1, 0, 6'h01, 0, 32'h401, 0, 32'h200);
    repeat (3) drv(0, 0, 0, 0, 6'h01, 0, 32'h401, 0, 0);
    // eret beats a pending interrupt, interrupt follows after settle
    drv(0, 0, 0, 0, 6'h00, 0, 32'h401, 32'h304, 0);
    drv(0, 0, 0, 0, 6'h01, 0, 32'h401, 32'h304, 0);
    drv(0, 1, 0, 1, 6'h01, 0, 32'h401, 32'h304, 32'h300);
    repeat (2) drv(0, 1, 0, 0, 6'h01, 0, 32'h401, 32'h304, 32'h300);
    drv(0, 1, 0, 0, 6'h01, 0, 32'h401, 32'h304, 32'h308);
    repeat (3) drv(0, 0, 0, 0, 6'h01, 0, 32'h401, 0, 0);
    // EXL blocks, then releases the pending interrupt
    drv(0, 0, 0, 0, 6'h00, 0, 32'h403, 0, 0);
    drv(0, 0, 0, 0, 6'h01, 0, 32'h403, 0, 0);
    repeat (3) drv(0, 1, 0, 0, 6'h01, 0, 32'h403, 0, 32'h400);
    drv(0, 1, 0, 0, 6'h01, 0, 32'h401, 0, 32'h410);
    repeat (3) drv(0, 0, 0, 0, 6'h01, 0, 32'h401, 0, 0);
    // timer level held high
    drv(0, 0, 0, 0, 6'h01, 0, 32'h101, 0, 0);
    drv(0, 0, 0, 0, 6'h01, 1, 32'h101, 0, 0);
    repeat (8) drv(0, 1, 0, 0, 6'h01, 1, 32'h101, 0, 32'h500);
    // reset during TAKE
    drv(0, 0, 0, 0, 6'h00, 0, 32'h401, 0, 0);
    drv(0, 0, 0, 0, 6'h01, 0, 32'h401, 0, 0);
    drv(0, 1, 1, 0, 6'h01, 0, 32'h401, 0, 32'h600);
    drv(1, 0, 0, 0, 6'h01, 0, 32'h401, 0, 0);
    repeat (3) drv(0, 1, 0, 0, 6'h01, 0, 32'h401, 0, 32'h700);
    // randomized traffic
    ri = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 6; b++) if ($urandom_range(5) == 0) ri[b] = ~ri[b];
      case ($urandom_range(5))
        0: st = 32'h0000_0401;
        1: st = 32'h0000_0403;
        2: st = 32'h0000_fd01;
        3: st = 32'hffff_0101;
        4: st = 32'h0000_0001;
        default: st = $urandom;
      endcase
      drv($urandom_range(199) == 0, $urandom_range(1), $urandom_range(3) == 0,
          $urandom_range(9) == 0, ri, $urandom_range(7) == 0 ? ~intimer : intimer,
          st, $urandom, $urandom);
    end
    repeat (4) drv(0, 0, 0, 0, ri, intimer, 32'h0, 0, 0);
    @(negedge clk);
    done = 1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h0000_0080; exception/interrupt handler entry PC.
REQ-002 SHALL have port clk, input, 1; clock, rising-edge.
REQ-003 SHALL have port rst, input, 1; reset, synchronous, active-high.
REQ-004 SHALL have port intr, input, 6; external hardware interrupt lines, level.
REQ-005 SHALL have port intimer, input, 1; timer interrupt level from CP0.
REQ-006 SHALL have port status, input, 32; CP0 Status: [0] IE, [1] EXL, [8] timer mask, [15:10] intr masks.
REQ-007 SHALL have port epc, input, 32; CP0 EPC, the return address for eret.
REQ-008 SHALL have port instValid, input, 1; instruction at the commit boundary this cycle.
REQ-009 SHALL have port isSyscall, input, 1; committing instruction is syscall.
REQ-010 SHALL have port isEret, input, 1; committing instruction is eret.
REQ-011 SHALL have port pc, input, 32; PC of the committing instruction.
REQ-012 SHALL have port excptype, output, 32; one-hot event code to CP0: 0x4 interrupt, 0x100 syscall, 0x200 eret, 0 none.
REQ-013 SHALL have port excpc, output, 32; PC handed to CP0 alongside excptype.
REQ-014 SHALL have port flush, output, 1; pipeline flush pulse.
REQ-015 SHALL have port newPc, output, 32; redirect target, valid when flush=1.
REQ-016 SHALL have port busy, output, 1; stall request to fetch/commit.

Function
REQ-017 SHALL keep rising-edge detectors on intr[5:0] and intimer (previous-value registers); a 0->1 transition sets the matching bit of pend[6:0] (bit0 timer, bits6:1 intr[5:0]).
REQ-018 SHALL keep a pend bit set until that source is serviced; held levels never re-set a bit without a new 0->1 edge.
REQ-019 SHALL compute intReq = status[0] & ~status[1] & |(pend & {status[15:10], status[8]}).
REQ-020 SHALL implement FSM IDLE, TAKE, SETTLE; only IDLE accepts events.
REQ-021 SHALL, in IDLE with instValid=1, select exactly one event by priority eret > interrupt > syscall; with instValid=0, take no event.
REQ-022 SHALL, on the eret select: next cycle excptype=0x200, excpc=pc, flush=1, newPc=epc.
REQ-023 SHALL, on the interrupt select: next cycle excptype=0x4, excpc=pc (interrupted instruction re-executes), flush=1, newPc=HANDLER_ADDR; clear the lowest-index set masked pend bit in the same edge.
REQ-024 SHALL, on the syscall select: next cycle excptype=0x100, excpc=pc, flush=1, newPc=HANDLER_ADDR; CP0 adds 4 for EPC.
REQ-025 SHALL drive excptype, flush for exactly one cycle (TAKE); excpc, newPc held until next event.
REQ-026 SHALL move TAKE->SETTLE unconditionally and SETTLE->IDLE unconditionally; SETTLE lets CP0 Status.EXL update before re-arbitration.
REQ-027 SHALL assert busy in TAKE and SETTLE, deassert in IDLE.
REQ-028 SHALL, if a source edge coincides with clearing that same bit, leave the bit set (set wins).
REQ-029 SHALL ignore isSyscall/isEret while busy=1; edges during TAKE/SETTLE still latch into pend.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set state IDLE, pend=0, edge registers=0, excptype=0, excpc=0, flush=0, newPc=0, busy=0; reset mid-TAKE/SETTLE aborts to IDLE.

Configuration
REQ-031 SHALL honour macro TIMER_INTR_EN: defined -> intimer feeds pend[0] per REQ-017; undefined -> pend[0] constant 0, intimer ignored, status[8] unused.

Verification
REQ-032 SHALL cover: status=0x0000_0401, intr[0] 0->1, instValid=1, pc=0x100 -> next cycle excptype=0x4, excpc=0x100, flush=1, newPc=0x80; busy 2 cycles; pend[1] cleared.
REQ-033 SHALL cover: isSyscall=1, isEret=0, instValid=1, pc=0x200, no pend -> excptype=0x100, excpc=0x200, newPc=0x80, one-cycle flush.
REQ-034 SHALL cover: isEret=1 and masked-enabled interrupt pending same cycle, epc=0x304 -> excptype=0x200, newPc=0x304; interrupt taken after SETTLE on next instValid.
REQ-035 SHALL cover: status=0x0000_0403 (EXL=1), intr[0] edge -> no excptype; after status becomes 0x0000_0401 and instValid=1 -> excptype=0x4.
REQ-036 SHALL cover: with TIMER_INTR_EN, status=0x0000_0101, intimer 0->1 held high -> exactly one 0x4 event; without macro -> none.
REQ-037 SHALL cover: rst=1 during TAKE -> next cycle busy=0, flush=0, excptype=0, pend=0.
